// File: rtl/mips_pipeline_pkg.sv
// ============================================================================
// Module : mips_pipeline_pkg
// Brief  : Shared constants and encodings for the MIPS pipeline front end.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mips_pipeline_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned WORD_BYTES       = 4;

    typedef enum logic [1:0] {
        PCSEL_SEQ = 2'd0,
        PCSEL_J   = 2'd1,
        PCSEL_BR  = 2'd2,
        PCSEL_JR  = 2'd3
    } pcsel_e;

endpackage

`default_nettype wire

// File: rtl/if_id_register.sv
// ============================================================================
// Module : if_id_register
// Brief  : IF/ID pipeline register; bubble beats hold, hold beats load.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module if_id_register
    import mips_pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        hold,
    input  logic        bubble,
    input  logic [31:0] instr_in,
    input  logic [31:0] pcplus4_in,
    output logic [31:0] instr,
    output logic [31:0] pcplus4,
    output logic        valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr   <= NOP_INSTR;
            pcplus4 <= 32'h0;
            valid   <= 1'b0;
        end else if (bubble) begin
            instr   <= NOP_INSTR;
            pcplus4 <= 32'h0;
            valid   <= 1'b0;
        end else if (hold) begin
            instr   <= instr;
            pcplus4 <= pcplus4;
            valid   <= valid;
        end else if (load) begin
            instr   <= instr_in;
            pcplus4 <= pcplus4_in;
            valid   <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module : instruction_fetch_unit
// Brief  : MIPS fetch stage: PC, next-PC mux, IF/ID register, address errors.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_unit
    import mips_pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_WORDS = 128
)(
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        JumpReg,
    input  logic [31:0] JumpRegTarget,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [25:0] JumpIndex,
    output logic [31:0] IMemAddress,
    input  logic [31:0] IMemInstruction,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic        AddrErr
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic [31:0] next_pc;
    pcsel_e      pcsel;
    logic        redirect;
    logic        misaligned;
    logic        out_of_range;
    logic        ifid_bubble;
    logic        ifid_load;
    logic        fetch_err;

    assign IMemAddress = pc;
    assign pc_plus4    = pc + 32'(WORD_BYTES);
    assign redirect    = JumpReg | BranchTaken | Jump;

    always_comb begin
        pcsel = PCSEL_SEQ;
        if (JumpReg)          pcsel = PCSEL_JR;
        else if (BranchTaken) pcsel = PCSEL_BR;
        else if (Jump)        pcsel = PCSEL_J;
    end

    always_comb begin
        target = pc_plus4;
        case (pcsel)
            PCSEL_JR:  target = JumpRegTarget;
            PCSEL_BR:  target = BranchTarget;
            PCSEL_J:   target = {IFID_PCPlus4[31:28], JumpIndex, 2'b00};
            default:   target = pc_plus4;
        endcase
    end

    // Misaligned targets are truncated to the word boundary and still taken.
    assign misaligned = redirect && (target[1:0] != 2'b00);
    assign next_pc    = {target[31:2], 2'b00};

    assign out_of_range = ({2'b00, pc[31:2]} >= 32'(IMEM_WORDS));
    assign ifid_bubble  = Flush | redirect | (~Stall & out_of_range);
    assign ifid_load    = ~Stall & ~out_of_range;
    assign fetch_err    = ~Flush & ~redirect & ~Stall & out_of_range;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= next_pc;
        end else if (!Stall) begin
            pc <= pc_plus4;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            AddrErr <= 1'b0;
        end else if (misaligned || fetch_err) begin
            AddrErr <= 1'b1;
        end
    end

    if_id_register u_if_id (
        .clk        (Clk),
        .rst_n      (Rst_n),
        .load       (ifid_load),
        .hold       (Stall),
        .bubble     (ifid_bubble),
        .instr_in   (IMemInstruction),
        .pcplus4_in (pc_plus4),
        .instr      (IFID_Instruction),
        .pcplus4    (IFID_PCPlus4),
        .valid      (IFID_Valid)
    );

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// Module : tb_instruction_fetch_unit
// Brief  : Directed-vector scoreboard bench for instruction_fetch_unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Stall, Flush, JumpReg, BranchTaken, Jump;
    logic [31:0] JumpRegTarget, BranchTarget;
    logic [25:0] JumpIndex;
    logic [31:0] IMemAddress, IMemInstruction;
    logic [31:0] IFID_Instruction, IFID_PCPlus4;
    logic        IFID_Valid, AddrErr;

    logic [31:0] b_addr, b_instr, b_p4;
    logic        b_valid, b_err;

    always #5 Clk = ~Clk;

    // Memory returns the byte address of each word as its contents.
    assign IMemInstruction = IMemAddress;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(128)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush),
        .JumpReg(JumpReg), .JumpRegTarget(JumpRegTarget),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .Jump(Jump), .JumpIndex(JumpIndex),
        .IMemAddress(IMemAddress), .IMemInstruction(IMemInstruction),
        .IFID_Instruction(IFID_Instruction), .IFID_PCPlus4(IFID_PCPlus4),
        .IFID_Valid(IFID_Valid), .AddrErr(AddrErr)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .IMEM_WORDS(128)) dut_wrap (
        .Clk(Clk), .Rst_n(Rst_n), .Stall(1'b0), .Flush(1'b0),
        .JumpReg(1'b0), .JumpRegTarget(32'h0),
        .BranchTaken(1'b0), .BranchTarget(32'h0),
        .Jump(1'b0), .JumpIndex(26'h0),
        .IMemAddress(b_addr), .IMemInstruction(b_addr),
        .IFID_Instruction(b_instr), .IFID_PCPlus4(b_p4),
        .IFID_Valid(b_valid), .AddrErr(b_err)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] p4;
        logic        v;
        logic        err;
        logic        b_chk;
        logic [31:0] b_pc;
        logic        b_v;
        logic        b_err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic        b_chk_n   = 1'b0;
    logic [31:0] b_pc_n    = 32'h0;
    logic        b_v_n     = 1'b0;
    logic        b_err_n   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: after each rising edge, compare DUT state against the oldest expectation.
    always @(posedge Clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc",        IMemAddress,              e.pc);
            chk("ifid_inst", IFID_Instruction,         e.instr);
            chk("ifid_pc4",  IFID_PCPlus4,             e.p4);
            chk("ifid_vld",  {31'b0, IFID_Valid},      {31'b0, e.v});
            chk("addrerr",   {31'b0, AddrErr},         {31'b0, e.err});
            if (e.b_chk) begin
                chk("wrap_pc",  b_addr,             e.b_pc);
                chk("wrap_vld", {31'b0, b_valid},   {31'b0, e.b_v});
                chk("wrap_err", {31'b0, b_err},     {31'b0, e.b_err});
            end
        end
    end

    task automatic step(
        input logic        rst_n_i,
        input logic        stall_i,
        input logic        flush_i,
        input logic        jr_i,
        input logic [31:0] jrt_i,
        input logic        br_i,
        input logic [31:0] brt_i,
        input logic        j_i,
        input logic [25:0] ji_i,
        input logic [31:0] epc,
        input logic [31:0] einstr,
        input logic [31:0] ep4,
        input logic        ev,
        input logic        eerr
    );
        exp_t e;
        @(negedge Clk);
        Rst_n = rst_n_i; Stall = stall_i; Flush = flush_i;
        JumpReg = jr_i; JumpRegTarget = jrt_i;
        BranchTaken = br_i; BranchTarget = brt_i;
        Jump = j_i; JumpIndex = ji_i;
        e.pc = epc; e.instr = einstr; e.p4 = ep4; e.v = ev; e.err = eerr;
        e.b_chk = b_chk_n; e.b_pc = b_pc_n; e.b_v = b_v_n; e.b_err = b_err_n;
        exp_q.push_back(e);
        b_chk_n = 1'b0;
    endtask

    // Shorthand: no control inputs, only expected values.
    task automatic idle(input logic [31:0] epc, input logic [31:0] einstr,
                        input logic [31:0] ep4, input logic ev, input logic eerr);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, epc, einstr, ep4, ev, eerr);
    endtask

    initial begin
        Rst_n = 1'b0; Stall = 0; Flush = 0; JumpReg = 0; BranchTaken = 0; Jump = 0;
        JumpRegTarget = 0; BranchTarget = 0; JumpIndex = 0;

        // Reset state, including the wrapping instance.
        b_chk_n = 1; b_pc_n = 32'hFFFF_FFFC; b_v_n = 0; b_err_n = 0;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);

        // Sequential fetch after release; wrap instance rolls to 0 and flags range.
        b_chk_n = 1; b_pc_n = 32'h0; b_v_n = 0; b_err_n = 1;
        idle(32'h04, 32'h00, 32'h04, 1, 0);
        b_chk_n = 1; b_pc_n = 32'h4; b_v_n = 1; b_err_n = 1;
        idle(32'h08, 32'h04, 32'h08, 1, 0);
        idle(32'h0C, 32'h08, 32'h0C, 1, 0);
        idle(32'h10, 32'h0C, 32'h10, 1, 0);

        // Stall three cycles at PC=0x10, then resume with no skip or duplicate.
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h10, 32'h0C, 32'h10, 1, 0);
        idle(32'h14, 32'h10, 32'h14, 1, 0);

        // jr to 0x60, then j with IFID_PCPlus4=0x64 and index 0xE -> 0x38.
        step(1, 0, 0, 1, 32'h60, 0, 0, 0, 0, 32'h60, 32'h0, 32'h0, 0, 0);
        idle(32'h64, 32'h60, 32'h64, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 26'h000000E, 32'h38, 32'h0, 32'h0, 0, 0);
        idle(32'h3C, 32'h38, 32'h3C, 1, 0);

        // jr beats branch, redirect beats stall.
        step(1, 1, 0, 1, 32'h40, 1, 32'h80, 0, 0, 32'h40, 32'h0, 32'h0, 0, 0);
        idle(32'h44, 32'h40, 32'h44, 1, 0);

        // Flush alone squashes IF/ID; flush with stall holds PC.
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h48, 32'h0, 32'h0, 0, 0);
        idle(32'h4C, 32'h48, 32'h4C, 1, 0);
        step(1, 1, 1, 0, 0, 0, 0, 0, 0, 32'h4C, 32'h0, 32'h0, 0, 0);
        idle(32'h50, 32'h4C, 32'h50, 1, 0);

        // Misaligned branch target 0x42 -> 0x40 with sticky error.
        step(1, 0, 0, 0, 0, 1, 32'h42, 0, 0, 32'h40, 32'h0, 32'h0, 0, 1);
        idle(32'h44, 32'h40, 32'h44, 1, 1);
        idle(32'h48, 32'h44, 32'h48, 1, 1);

        // Reset mid-operation clears everything, including the sticky error.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);

        // Walk off the end of memory: 0x1FC is last valid word, 0x200 is out of range.
        step(1, 0, 0, 1, 32'h1FC, 0, 0, 0, 0, 32'h1FC, 32'h0, 32'h0, 0, 0);
        idle(32'h200, 32'h1FC, 32'h200, 1, 0);
        idle(32'h204, 32'h0, 32'h0, 0, 1);
        idle(32'h208, 32'h0, 32'h0, 0, 1);

        @(negedge Clk);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge Clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
